// File: rtl/wb_write_arbiter_if.sv
// Bundle of the writeback arbiter's ALU, load and register-file write-port signals.
interface wb_write_arbiter_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned NUM_REGS   = 15
);
    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_dest;
    logic [DATA_W-1:0]     alu_result;
    logic                  ld_issue;
    logic [REG_ADDR_W-1:0] ld_dest;
    logic                  ld_rsp_valid;
    logic [REG_ADDR_W-1:0] ld_rsp_dest;
    logic [DATA_W-1:0]     ld_rsp_data;
    logic                  ld_rsp_ready;
    logic                  stall;
    logic [NUM_REGS-1:0]   pending;
    logic [REG_ADDR_W-1:0] Dest_wb;
    logic [DATA_W-1:0]     Result_WB;
    logic                  writeBackEn;

    // Pipeline / memory-controller side: drives requests, observes the write port.
    modport master (
        output alu_valid, alu_dest, alu_result,
        output ld_issue, ld_dest,
        output ld_rsp_valid, ld_rsp_dest, ld_rsp_data,
        input  ld_rsp_ready, stall, pending,
        input  Dest_wb, Result_WB, writeBackEn
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_dest, alu_result,
        input  ld_issue, ld_dest,
        input  ld_rsp_valid, ld_rsp_dest, ld_rsp_data,
        output ld_rsp_ready, stall, pending,
        output Dest_wb, Result_WB, writeBackEn
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges the ALU result path and variable-latency load returns onto the
// single register-file write port, with a pending-load scoreboard and a small return FIFO.
module wb_write_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned NUM_REGS   = 15,
    parameter int unsigned LQ_DEPTH   = 2
) (
    input logic               clk,
    input logic               rst,
    wb_write_arbiter_if.slave bus
);
    localparam int unsigned PtrW     = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int unsigned CntW     = $clog2(LQ_DEPTH + 1);
    localparam int unsigned RegSpace = 2 ** REG_ADDR_W;
    // Index NUM_REGS is the PC: never written, never tracked.
    localparam logic [REG_ADDR_W-1:0] PcIdx = REG_ADDR_W'(NUM_REGS);

    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [REG_ADDR_W-1:0] dest_wb_q, dest_wb_d;
    logic [DATA_W-1:0]     result_wb_q, result_wb_d;
    logic                  wb_en_q, wb_en_d;

    logic [REG_ADDR_W-1:0] lq_dest_q [LQ_DEPTH];
    logic [REG_ADDR_W-1:0] lq_dest_d [LQ_DEPTH];
    logic [DATA_W-1:0]     lq_data_q [LQ_DEPTH];
    logic [DATA_W-1:0]     lq_data_d [LQ_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;

    logic [RegSpace-1:0]   pend_ext;
    logic                  stall;
    logic                  ready;
    logic                  fifo_empty;
    logic                  alu_wr;
    logic                  deq;
    logic                  bypass;
    logic                  enq;
    logic                  load_wr;
    logic [REG_ADDR_W-1:0] load_dest;
    logic [DATA_W-1:0]     load_data;
    logic                  set_en;
    logic [NUM_REGS-1:0]   set_vec;
    logic [NUM_REGS-1:0]   clr_vec;

    // Zero-extended scoreboard so the PC index reads as never pending.
    assign pend_ext = RegSpace'(pending_q);

    // Hazard detection and write-port arbitration.
    always_comb begin
        stall      = (bus.alu_valid & pend_ext[bus.alu_dest]) |
                     (bus.ld_issue & pend_ext[bus.ld_dest]);
        // Ready depends only on the registered count, not on this cycle's dequeue.
        ready      = (count_q != CntW'(LQ_DEPTH));
        fifo_empty = (count_q == '0);
        alu_wr     = bus.alu_valid & ~stall & (bus.alu_dest != PcIdx);
        deq        = ~alu_wr & ~fifo_empty;
        bypass     = ~alu_wr & fifo_empty & bus.ld_rsp_valid;
        enq        = bus.ld_rsp_valid & ready & ~bypass;
        load_dest  = deq ? lq_dest_q[rd_ptr_q] : bus.ld_rsp_dest;
        load_data  = deq ? lq_data_q[rd_ptr_q] : bus.ld_rsp_data;
        // Loads to the PC are consumed but produce no write.
        load_wr    = (deq | bypass) & (load_dest != PcIdx);
        set_en     = bus.ld_issue & ~stall;
    end

    // Write-port next state: ALU first, then FIFO head, then bypass; otherwise hold.
    always_comb begin
        wb_en_d     = 1'b0;
        dest_wb_d   = dest_wb_q;
        result_wb_d = result_wb_q;
        if (alu_wr) begin
            wb_en_d     = 1'b1;
            dest_wb_d   = bus.alu_dest;
            result_wb_d = bus.alu_result;
        end else if (load_wr) begin
            wb_en_d     = 1'b1;
            dest_wb_d   = load_dest;
            result_wb_d = load_data;
        end
    end

    // Scoreboard: set on unstalled issue, clear on the load's write.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            set_vec[i] = set_en & (bus.ld_dest == REG_ADDR_W'(i));
            clr_vec[i] = load_wr & (load_dest == REG_ADDR_W'(i));
        end
        pending_d = (pending_q | set_vec) & ~clr_vec;
    end

    // Load-return FIFO pointers, count and storage.
    always_comb begin
        lq_dest_d = lq_dest_q;
        lq_data_d = lq_data_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (enq) begin
            lq_dest_d[wr_ptr_q] = bus.ld_rsp_dest;
            lq_data_d[wr_ptr_q] = bus.ld_rsp_data;
            wr_ptr_d            = wr_ptr_q + PtrW'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(enq) - CntW'(deq);
    end

    // State registers; reset discards queued loads and clears the scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            dest_wb_q   <= '0;
            result_wb_q <= '0;
            wb_en_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                lq_dest_q[i] <= '0;
                lq_data_q[i] <= '0;
            end
        end else begin
            pending_q   <= pending_d;
            dest_wb_q   <= dest_wb_d;
            result_wb_q <= result_wb_d;
            wb_en_q     <= wb_en_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lq_dest_q   <= lq_dest_d;
            lq_data_q   <= lq_data_d;
        end
    end

    assign bus.ld_rsp_ready = ready;
    assign bus.stall        = stall;
    assign bus.pending      = pending_q;
    assign bus.Dest_wb      = dest_wb_q;
    assign bus.Result_WB    = result_wb_q;
    assign bus.writeBackEn  = wb_en_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed, table-driven bench for wb_write_arbiter.
module tb_wb_write_arbiter;
    logic clk;
    logic rst;

    wb_write_arbiter_if bus ();

    wb_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus: inputs, pre-edge combinational expectations, post-edge registers.
    typedef struct packed {
        logic        av;
        logic [3:0]  ad;
        logic [31:0] ar;
        logic        li;
        logic [3:0]  ld;
        logic        rv;
        logic [3:0]  rd;
        logic [31:0] rdat;
        logic        es;
        logic        er;
        logic        ewe;
        logic [3:0]  edst;
        logic [31:0] eres;
        logic [14:0] epend;
    } vec_t;

    localparam int NumVec = 20;
    vec_t vecs [NumVec];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [3:0] ad, input logic [31:0] ar,
                         input logic li, input logic [3:0] ld,
                         input logic rv, input logic [3:0] rd, input logic [31:0] rdat);
        bus.alu_valid    = av;
        bus.alu_dest     = ad;
        bus.alu_result   = ar;
        bus.ld_issue     = li;
        bus.ld_dest      = ld;
        bus.ld_rsp_valid = rv;
        bus.ld_rsp_dest  = rd;
        bus.ld_rsp_data  = rdat;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic check_port(input string tag, input logic we, input logic [3:0] dst,
                              input logic [31:0] res, input logic [14:0] pend);
        check({tag, " writeBackEn"}, 32'(bus.writeBackEn), 32'(we));
        check({tag, " Dest_wb"}, 32'(bus.Dest_wb), 32'(dst));
        check({tag, " Result_WB"}, bus.Result_WB, res);
        check({tag, " pending"}, 32'(bus.pending), 32'(pend));
    endtask

    // Every accepted response must target an outstanding load (PC responses excepted).
    logic [15:0] pend16;
    assign pend16 = {1'b0, bus.pending};
    always @(posedge clk) begin
        if (!rst && bus.ld_rsp_valid && bus.ld_rsp_ready && bus.ld_rsp_dest != 4'd15) begin
            assert (pend16[bus.ld_rsp_dest])
            else $error("load response to R%0d with no pending load", bus.ld_rsp_dest);
        end
    end

    initial begin
        //            av  ad     ar            li  ld     rv  rd     rdat
        //            es  er   ewe  edst   eres          epend
        vecs[0]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0,
                     1'b0, 1'b1, 1'b0, 4'd0, 32'h0, 15'h0000};
        vecs[1]  = '{1'b1, 4'd3, 32'h12345678, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0,
                     1'b0, 1'b1, 1'b1, 4'd3, 32'h12345678, 15'h0000};
        vecs[2]  = '{1'b1, 4'd15, 32'hDEAD, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0,
                     1'b0, 1'b1, 1'b0, 4'd3, 32'h12345678, 15'h0000};
        vecs[3]  = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 1'b0, 4'd0, 32'h0,
                     1'b0, 1'b1, 1'b0, 4'd3, 32'h12345678, 15'h0080};
        vecs[4]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1, 4'd7, 32'hCAFEBABE,
                     1'b0, 1'b1, 1'b1, 4'd7, 32'hCAFEBABE, 15'h0000};
        vecs[5]  = '{1'b1, 4'd5, 32'h11, 1'b1, 4'd1, 1'b0, 4'd0, 32'h0,
                     1'b0, 1'b1, 1'b1, 4'd5, 32'h11, 15'h0002};
        vecs[6]  = '{1'b1, 4'd6, 32'h22, 1'b1, 4'd2, 1'b0, 4'd0, 32'h0,
                     1'b0, 1'b1, 1'b1, 4'd6, 32'h22, 15'h0006};
        vecs[7]  = '{1'b1, 4'd5, 32'h33, 1'b0, 4'd0, 1'b1, 4'd1, 32'hA1,
                     1'b0, 1'b1, 1'b1, 4'd5, 32'h33, 15'h0006};
        vecs[8]  = '{1'b1, 4'd6, 32'h44, 1'b0, 4'd0, 1'b1, 4'd2, 32'hA2,
                     1'b0, 1'b1, 1'b1, 4'd6, 32'h44, 15'h0006};
        vecs[9]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0,
                     1'b0, 1'b0, 1'b1, 4'd1, 32'hA1, 15'h0004};
        vecs[10] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0,
                     1'b0, 1'b1, 1'b1, 4'd2, 32'hA2, 15'h0000};
        vecs[11] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 1'b0, 4'd0, 32'h0,
                     1'b0, 1'b1, 1'b0, 4'd2, 32'hA2, 15'h0010};
        vecs[12] = '{1'b1, 4'd4, 32'h44444444, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0,
                     1'b1, 1'b1, 1'b0, 4'd2, 32'hA2, 15'h0010};
        vecs[13] = '{1'b1, 4'd4, 32'h44444444, 1'b0, 4'd0, 1'b1, 4'd4, 32'hB4,
                     1'b1, 1'b1, 1'b1, 4'd4, 32'hB4, 15'h0000};
        vecs[14] = '{1'b1, 4'd4, 32'h44444444, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0,
                     1'b0, 1'b1, 1'b1, 4'd4, 32'h44444444, 15'h0000};
        vecs[15] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 1'b0, 4'd0, 32'h0,
                     1'b0, 1'b1, 1'b0, 4'd4, 32'h44444444, 15'h0200};
        vecs[16] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 1'b0, 4'd0, 32'h0,
                     1'b1, 1'b1, 1'b0, 4'd4, 32'h44444444, 15'h0200};
        vecs[17] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 1'b1, 4'd9, 32'h99,
                     1'b1, 1'b1, 1'b1, 4'd9, 32'h99, 15'h0000};
        vecs[18] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 1'b0, 4'd0, 32'h0,
                     1'b0, 1'b1, 1'b0, 4'd9, 32'h99, 15'h0200};
        vecs[19] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1, 4'd9, 32'h98,
                     1'b0, 1'b1, 1'b1, 4'd9, 32'h98, 15'h0000};

        // Power-on reset.
        rst = 1'b1;
        idle();
        #2;
        check_port("reset", 1'b0, 4'd0, 32'h0, 15'h0);
        check("reset ready", 32'(bus.ld_rsp_ready), 32'd1);
        check("reset stall", 32'(bus.stall), 32'd0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        // Table: drive just after the edge, check combinational outputs, then registers.
        for (int i = 0; i < NumVec; i++) begin
            drive(vecs[i].av, vecs[i].ad, vecs[i].ar, vecs[i].li, vecs[i].ld,
                  vecs[i].rv, vecs[i].rd, vecs[i].rdat);
            #1;
            check($sformatf("v%0d stall", i), 32'(bus.stall), 32'(vecs[i].es));
            check($sformatf("v%0d ready", i), 32'(bus.ld_rsp_ready), 32'(vecs[i].er));
            @(posedge clk);
            #1;
            check_port($sformatf("v%0d", i), vecs[i].ewe, vecs[i].edst, vecs[i].eres,
                       vecs[i].epend);
        end

        // Asynchronous reset mid-cycle with two queued loads.
        drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd1, 1'b0, 4'd0, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 1'b0, 4'd0, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 4'd5, 32'h55, 1'b0, 4'd0, 1'b1, 4'd1, 32'hC1);
        @(posedge clk); #1;
        drive(1'b1, 4'd6, 32'h66, 1'b0, 4'd0, 1'b1, 4'd2, 32'hC2);
        @(posedge clk); #1;
        idle();
        #1;
        check("full ready", 32'(bus.ld_rsp_ready), 32'd0);
        check("full pending", 32'(bus.pending), 32'h0006);
        check("full Result_WB", bus.Result_WB, 32'h66);
        #1 rst = 1'b1;
        #1;
        check_port("async reset", 1'b0, 4'd0, 32'h0, 15'h0);
        check("async reset ready", 32'(bus.ld_rsp_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_port("post reset", 1'b0, 4'd0, 32'h0, 15'h0);
        @(posedge clk); #1;
        check_port("queue discarded", 1'b0, 4'd0, 32'h0, 15'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
